data_mem_ctrl: RTL

//  Parametrised data memory with a request/ready handshake for the multicycle RISC-V core.

---
 rtl/data_mem_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/data_mem_ctrl.sv
// Byte-addressable data memory with a request/ready handshake and programmable wait states.
// Rejects illegal, misaligned or out-of-range requests with err on the response strobe.
module data_mem_ctrl #(
  parameter int DEPTH     = 512,
  parameter int LATENCY   = 2,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        ready_q;
  logic        busy_q;
  logic        err_q;

  logic        rd_q;
  logic        wr_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] din_q;

  logic          req_d;
  logic          bad_d;
  logic          commit_d;
  logic [AW-1:0] idx_d;
  logic [3:0]    be_d;
  logic [31:0]   wdata_d;
  logic [31:0]   rd_word;
  logic [7:0]    byte_d;
  logic [15:0]   half_d;
  logic [31:0]   dout_d;

  assign req_d = MemRead | MemWrite;
  assign idx_d = addr_q[AW+1:2];

  // Legality is judged on the captured request, never on the live inputs.
  always_comb begin
    bad_d = 1'b0;
    if (rd_q && wr_q) bad_d = 1'b1;
    if (size_q == 2'b11) bad_d = 1'b1;
    if (size_q == 2'b01 && addr_q[0]) bad_d = 1'b1;
    if (size_q == 2'b10 && addr_q[1:0] != 2'b00) bad_d = 1'b1;
    if ((addr_q >> (AW + 2)) != 32'd0) bad_d = 1'b1;
  end

  assign commit_d = (state_q == WAIT) && (cnt_q == 4'd0) && !rst && !bad_d;

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = din_q;
    case (size_q)
      2'b00: begin
        be_d    = 4'b0001 << addr_q[1:0];
        wdata_d = {4{din_q[7:0]}};
      end
      2'b01: begin
        be_d    = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{din_q[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = din_q;
      end
    endcase
  end

  // One RAM per byte lane so partial stores need no read-modify-write.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem_q [DEPTH];
    logic [7:0] lane_rd_q;

    always_ff @(posedge clk) begin
      if (commit_d && wr_q && be_d[gi]) begin
        lane_mem_q[idx_d] <= wdata_d[gi*8 +: 8];
      end
      if (commit_d && rd_q) begin
        lane_rd_q <= lane_mem_q[idx_d];
      end
    end

    assign rd_word[gi*8 +: 8] = lane_rd_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= RESP;
            ready_q <= 1'b1;
            err_q   <= bad_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          // RESP accepts like IDLE so back-to-back requests lose no cycle.
          err_q <= 1'b0;
          if (req_d) begin
            state_q <= WAIT;
            cnt_q   <= 4'(LATENCY);
            busy_q  <= 1'b1;
            rd_q    <= MemRead;
            wr_q    <= MemWrite;
            uns_q   <= unsigned_ld;
            size_q  <= size;
            addr_q  <= addr;
            din_q   <= din;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    byte_d = rd_word[{addr_q[1:0], 3'b000} +: 8];
    half_d = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    dout_d = '0;
    if (ready_q && rd_q && !err_q) begin
      case (size_q)
        2'b00:   dout_d = uns_q ? {24'd0, byte_d} : {{24{byte_d[7]}}, byte_d};
        2'b01:   dout_d = uns_q ? {16'd0, half_d} : {{16{half_d[15]}}, half_d};
        default: dout_d = rd_word;
      endcase
    end
  end

  assign dout  = dout_d;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule
